// File: rtl/task_latency_pkg.sv
// rtl/task_latency_pkg.sv - shared types, flag indices and saturating-add helper for the latency monitor
package task_latency_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_e;

  localparam int FLG_OVR  = 0;
  localparam int FLG_ORPH = 1;

  // Operands are zero-extended to 64 bits; the result clamps at the all-ones value of width w (w <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [64:0] s;
    logic [64:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    return (s > lim) ? lim[63:0] : s[63:0];
  endfunction

endpackage

// File: rtl/task_latency_chan.sv
// rtl/task_latency_chan.sv - one latency channel: IDLE/RUN timer plus last/min/max/sum/count and sticky flags
module task_latency_chan
  import task_latency_pkg::*;
#(
  parameter int LAT_W        = 32,
  parameter int SUM_W        = 48,
  parameter int SMP_W        = 16,
  parameter int RESTART_MODE = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_clr,
  output logic             o_busy,
  output logic [LAT_W-1:0] o_last,
  output logic [LAT_W-1:0] o_min,
  output logic [LAT_W-1:0] o_max,
  output logic [SUM_W-1:0] o_sum,
  output logic [SMP_W-1:0] o_cnt,
  output logic [1:0]       o_flags
);

  chan_state_e      state_q, state_d;
  logic [LAT_W-1:0] ctr_q, ctr_d;
  logic [LAT_W-1:0] last_q, last_d;
  logic [LAT_W-1:0] min_q, min_d;
  logic [LAT_W-1:0] max_q, max_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SMP_W-1:0] cnt_q, cnt_d;
  logic [1:0]       flags_q, flags_d;

  logic             rec;
  logic [LAT_W-1:0] smp;
  logic [LAT_W-1:0] ctr_inc;

  // ctr_q holds (cycles since start - 1), so the sample on stop is ctr_q + 1.
  assign ctr_inc = LAT_W'(sat_add(64'(ctr_q), 64'd1, LAT_W));

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    last_d  = last_q;
    min_d   = min_q;
    max_d   = max_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    rec     = 1'b0;
    smp     = '0;
    if (i_clr) begin
      state_d = IDLE;
      ctr_d   = '0;
      last_d  = '0;
      min_d   = '1;
      max_d   = '0;
      sum_d   = '0;
      cnt_d   = '0;
      flags_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start && i_stop) begin
            rec = 1'b1;
          end else if (i_start) begin
            state_d = RUN;
            ctr_d   = '0;
          end else if (i_stop) begin
            flags_d[FLG_ORPH] = 1'b1;
          end
        end
        RUN: begin
          ctr_d = ctr_inc;
          if (i_stop) begin
            rec = 1'b1;
            smp = ctr_inc;
            if (i_start) ctr_d = '0;
            else         state_d = IDLE;
          end else if (i_start) begin
            flags_d[FLG_OVR] = 1'b1;
            if (RESTART_MODE == 1) ctr_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
      if (rec) begin
        last_d = smp;
        if (smp < min_q) min_d = smp;
        if (smp > max_q) max_d = smp;
        sum_d = SUM_W'(sat_add(64'(sum_q), 64'(smp), SUM_W));
        cnt_d = SMP_W'(sat_add(64'(cnt_q), 64'd1, SMP_W));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      last_q  <= '0;
      min_q   <= '1;
      max_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      last_q  <= last_d;
      min_q   <= min_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  assign o_busy  = (state_q == RUN);
  assign o_last  = last_q;
  assign o_min   = min_q;
  assign o_max   = max_q;
  assign o_sum   = sum_q;
  assign o_cnt   = cnt_q;
  assign o_flags = flags_q;

endmodule

// File: rtl/task_latency_stats.sv
// rtl/task_latency_stats.sv - multi-channel task latency monitor with registered per-channel readout
module task_latency_stats
  import task_latency_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int LAT_W        = 32,
  parameter int SUM_W        = 48,
  parameter int SMP_W        = 16,
  parameter int RESTART_MODE = 0,
  localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_start,
  input  logic [NUM_CH-1:0] i_stop,
  input  logic [NUM_CH-1:0] i_clr,
  input  logic              i_rd_en,
  input  logic [SEL_W-1:0]  i_rd_sel,
  output logic              o_rd_valid,
  output logic [LAT_W-1:0]  o_rd_last,
  output logic [LAT_W-1:0]  o_rd_min,
  output logic [LAT_W-1:0]  o_rd_max,
  output logic [SUM_W-1:0]  o_rd_sum,
  output logic [SMP_W-1:0]  o_rd_cnt,
  output logic [1:0]        o_rd_flags,
  output logic [NUM_CH-1:0] o_busy
);

  localparam logic [SEL_W:0] NUM_CH_L = (SEL_W + 1)'(NUM_CH);

  logic [LAT_W-1:0] last_w  [NUM_CH];
  logic [LAT_W-1:0] min_w   [NUM_CH];
  logic [LAT_W-1:0] max_w   [NUM_CH];
  logic [SUM_W-1:0] sum_w   [NUM_CH];
  logic [SMP_W-1:0] cnt_w   [NUM_CH];
  logic [1:0]       flags_w [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    task_latency_chan #(
      .LAT_W        (LAT_W),
      .SUM_W        (SUM_W),
      .SMP_W        (SMP_W),
      .RESTART_MODE (RESTART_MODE)
    ) u_chan (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (i_start[k]),
      .i_stop  (i_stop[k]),
      .i_clr   (i_clr[k]),
      .o_busy  (o_busy[k]),
      .o_last  (last_w[k]),
      .o_min   (min_w[k]),
      .o_max   (max_w[k]),
      .o_sum   (sum_w[k]),
      .o_cnt   (cnt_w[k]),
      .o_flags (flags_w[k])
    );
  end

  logic             rd_valid_q, rd_valid_d;
  logic [LAT_W-1:0] rd_last_q, rd_last_d;
  logic [LAT_W-1:0] rd_min_q, rd_min_d;
  logic [LAT_W-1:0] rd_max_q, rd_max_d;
  logic [SUM_W-1:0] rd_sum_q, rd_sum_d;
  logic [SMP_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]       rd_flags_q, rd_flags_d;
  logic             sel_ok;

  assign sel_ok = ({1'b0, i_rd_sel} < NUM_CH_L);

  // Channel stats are registers, so sampling them now returns the pre-update view of this cycle.
  always_comb begin
    rd_valid_d = i_rd_en;
    rd_last_d  = rd_last_q;
    rd_min_d   = rd_min_q;
    rd_max_d   = rd_max_q;
    rd_sum_d   = rd_sum_q;
    rd_cnt_d   = rd_cnt_q;
    rd_flags_d = rd_flags_q;
    if (i_rd_en) begin
      if (sel_ok) begin
        rd_last_d  = last_w[i_rd_sel];
        rd_min_d   = min_w[i_rd_sel];
        rd_max_d   = max_w[i_rd_sel];
        rd_sum_d   = sum_w[i_rd_sel];
        rd_cnt_d   = cnt_w[i_rd_sel];
        rd_flags_d = flags_w[i_rd_sel];
      end else begin
        rd_last_d  = '0;
        rd_min_d   = '0;
        rd_max_d   = '0;
        rd_sum_d   = '0;
        rd_cnt_d   = '0;
        rd_flags_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= '0;
      rd_min_q   <= '0;
      rd_max_q   <= '0;
      rd_sum_q   <= '0;
      rd_cnt_q   <= '0;
      rd_flags_q <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_min_q   <= rd_min_d;
      rd_max_q   <= rd_max_d;
      rd_sum_q   <= rd_sum_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_flags_q <= rd_flags_d;
    end
  end

  assign o_rd_valid = rd_valid_q;
  assign o_rd_last  = rd_last_q;
  assign o_rd_min   = rd_min_q;
  assign o_rd_max   = rd_max_q;
  assign o_rd_sum   = rd_sum_q;
  assign o_rd_cnt   = rd_cnt_q;
  assign o_rd_flags = rd_flags_q;

endmodule

// File: doc/task_latency_stats.md
Name: task_latency_stats

Overview:
Multi-channel task latency monitor and successor to the single-channel latency counter. Each channel times start→stop intervals and keeps running statistics: last, min, max, saturating sum and sample count. Host/UART debug logic reads one channel per request through a registered readout port. Sits beside the task datapath and only observes its valid strobes.

Parameters:
NUM_CH, 4, number of independent channels (1..16)
LAT_W, 32, latency counter and last/min/max width
SUM_W, 48, accumulated-latency width
SMP_W, 16, sample-count width
RESTART_MODE, 0, start while running: 0 = ignore, 1 = discard current interval and restart

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_start  in  NUM_CH  per-channel start strobe (task accepted)
i_stop  in  NUM_CH  per-channel stop strobe (result produced)
i_clr  in  NUM_CH  per-channel synchronous clear of stats and flags
i_rd_en  in  1  readout request, single-cycle
i_rd_sel  in  $clog2(NUM_CH) (min 1)  channel to read
o_rd_valid  out  1  readout data valid, one-cycle pulse
o_rd_last  out  LAT_W  last completed latency
o_rd_min  out  LAT_W  minimum latency
o_rd_max  out  LAT_W  maximum latency
o_rd_sum  out  SUM_W  sum of latencies
o_rd_cnt  out  SMP_W  completed sample count
o_rd_flags  out  2  [0] overrun (start while running), [1] orphan (stop while idle); sticky
o_busy  out  NUM_CH  channel in RUN state

Behaviour:
- Reset (i_rst=1): all channels IDLE, counter 0, last 0, min all-ones, max 0, sum 0, cnt 0, flags 0; o_rd_valid 0, all o_rd_* 0, o_busy 0.
- Per-channel FSM, IDLE/RUN; o_busy = (state==RUN), registered.
- IDLE: start → RUN, counter ← 0. start & stop same cycle → record sample 0, stay IDLE. stop alone → ignored, orphan flag set.
- RUN: counter +1 every cycle, saturating at all-ones (no wrap). stop → record sample = counter+1 (saturated), → IDLE. stop & start same cycle → record sample, counter ← 0, stay RUN (back-to-back). start alone: mode 0 ignore; mode 1 counter ← 0; both set overrun flag.
- Latency definition: start in cycle t, stop in cycle t+N → sample N.
- Record sample S: last ← S; min ← min(min,S); max ← max(max,S); sum ← sum+S saturating at all-ones; cnt ← cnt+1 saturating at all-ones. Sum and cnt saturate independently.
- i_clr[k]: channel k returns to reset values, state IDLE. Takes priority over start/stop in the same cycle; those events are dropped.
- Readout: i_rd_en in cycle t → o_rd_valid=1 and o_rd_* = the selected channel's stats as held at the start of cycle t, i.e. pre-update if a sample lands in cycle t. o_rd_valid is high in cycle t+1 only. o_rd_* hold their value until the next read. i_rd_sel ≥ NUM_CH → o_rd_valid=1, all data 0.
- min reads all-ones while cnt=0; software checks cnt.
- Channels fully independent; there is no cross-channel arbitration.
- i_rst mid-interval: interval discarded, nothing recorded.

Decomposition:
- Package task_latency_pkg: chan_state_e {IDLE, RUN}, flag bit index localparams (FLG_OVR=0, FLG_ORPH=1), and a parametrised-width helper for the saturating add.
- Sub-module task_latency_chan: one channel (FSM, counter, stats, flags), instantiated NUM_CH times with generate. The top holds only the readout mux and output registers.

Test Plan:
- Ch0: start cycle 10, stop cycle 15 → read: last 5, min 5, max 5, sum 5, cnt 1, flags 0.
- Ch1: intervals 3, 7, 2 → last 2, min 2, max 7, sum 12, cnt 3. Ch0 stats unchanged.
- Ch2 start/stop same cycle in IDLE → sample 0 (min 0, cnt 1). Then stop+start same cycle in RUN after 4 cycles → sample 4, o_busy stays 1.
- Ch3: start, then start again 3 cycles later, stop 5 cycles after that. RESTART_MODE=0 → sample 8, flags 2'b01. RESTART_MODE=1 → sample 5, flags 2'b01. Stop while idle → flags 2'b11.
- LAT_W=4: interval 20 cycles → sample 15. SMP_W=2: 5 samples → cnt 3. SUM_W=5: samples 15+15+15 → sum 31.
- i_clr[0] with coincident stop → no sample, stats reset. i_rd_en with i_rd_sel=NUM_CH → valid pulse, zeros. A read in the same cycle as a recorded sample returns the old values.
